// File: rtl/bp_pkg.sv
// Shared definitions for the fetch-side branch predictor: default geometry,
// 2-bit counter encodings and the logical layout of one table entry.
package bp_pkg;

  localparam int XLEN_D     = 32;
  localparam int IDX_BITS_D = 6;
  localparam int TAG_BITS_D = 8;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_t;

  typedef struct packed {
    logic                  valid;
    logic [TAG_BITS_D-1:0] tag;
    ctr_t                  ctr;
    logic [XLEN_D-1:0]     target;
  } bp_entry_t;

endpackage

// File: rtl/branch_predictor_sat_counter2.sv
// 2-bit saturating counter next-state function; shared by the single update port.
module sat_counter2
  import bp_pkg::*;
(
  input  ctr_t ctr,
  input  logic inc,
  input  logic force_st,
  output ctr_t ctr_next
);

  always_comb begin
    ctr_next = ctr;
    if (force_st) begin
      ctr_next = ST;
    end else if (inc) begin
      ctr_next = (ctr == ST) ? ST : ctr_t'(ctr + 2'd1);
    end else begin
      ctr_next = (ctr == SNT) ? SNT : ctr_t'(ctr - 2'd1);
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped direction/target predictor: zero-latency lookup for the F-stage PC,
// training from X-stage resolution, mispredict detection and event counters.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int XLEN     = XLEN_D,
  parameter int IDX_BITS = IDX_BITS_D,
  parameter int TAG_BITS = TAG_BITS_D
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc_f,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  input  logic            upd_valid,
  input  logic [XLEN-1:0] upd_pc,
  input  logic            upd_is_jump,
  input  logic            upd_taken,
  input  logic [XLEN-1:0] upd_target,
  input  logic            upd_pred_taken,
  input  logic [XLEN-1:0] upd_pred_target,
  output logic            mispredict,
  output logic [XLEN-1:0] redirect_pc,
  output logic [31:0]     cnt_branches,
  output logic [31:0]     cnt_mispredicts
);

  localparam int ENTRIES = 2 ** IDX_BITS;

  // Valid lives in flops so reset clears the whole table in one edge.
  logic [ENTRIES-1:0]  valid_q;
  logic [TAG_BITS-1:0] tag_mem [ENTRIES];
  ctr_t                ctr_mem [ENTRIES];
  logic [XLEN-1:0]     tgt_mem [ENTRIES];

  logic [IDX_BITS-1:0] f_idx, u_idx;
  logic [TAG_BITS-1:0] f_tag, u_tag;
  logic                f_hit, u_hit;
  logic                alloc, tgt_wr;
  ctr_t                ctr_next;

  assign f_idx = pc_f[IDX_BITS+1:2];
  assign f_tag = pc_f[IDX_BITS+TAG_BITS+1:IDX_BITS+2];
  assign u_idx = upd_pc[IDX_BITS+1:2];
  assign u_tag = upd_pc[IDX_BITS+TAG_BITS+1:IDX_BITS+2];

  assign f_hit       = valid_q[f_idx] && (tag_mem[f_idx] == f_tag);
  assign pred_taken  = f_hit && ctr_mem[f_idx][1];
  assign pred_target = f_hit ? tgt_mem[f_idx] : pc_f + XLEN'(4);

  assign u_hit  = valid_q[u_idx] && (tag_mem[u_idx] == u_tag);
  assign alloc  = upd_valid && !u_hit && upd_taken;
  assign tgt_wr = upd_valid && (u_hit ? (upd_taken || upd_is_jump) : upd_taken);

  assign mispredict  = upd_valid && ((upd_taken != upd_pred_taken) ||
                                     (upd_taken && (upd_target != upd_pred_target)));
  assign redirect_pc = upd_taken ? upd_target : upd_pc + XLEN'(4);

  sat_counter2 u_sat (
    .ctr      (ctr_mem[u_idx]),
    .inc      (upd_taken),
    .force_st (upd_is_jump),
    .ctr_next (ctr_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else if (alloc) begin
      valid_q[u_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        ctr_mem[i] <= WNT;
      end
    end else if (upd_valid && u_hit) begin
      ctr_mem[u_idx] <= ctr_next;
    end else if (alloc) begin
      ctr_mem[u_idx] <= upd_is_jump ? ST : WT;
    end
  end

  // Tags and targets carry no reset; valid_q masks them until written.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (alloc) begin
        tag_mem[u_idx] <= u_tag;
      end
      if (tgt_wr) begin
        tgt_mem[u_idx] <= upd_target;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_branches    <= '0;
      cnt_mispredicts <= '0;
    end else if (upd_valid) begin
      cnt_branches    <= cnt_branches + 32'd1;
      cnt_mispredicts <= cnt_mispredicts + {31'd0, mispredict};
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: abstract table model checked every cycle,
// plus hand-computed literal expectations for the key scenarios.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc_f = '0;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        upd_valid = 1'b0;
  logic [31:0] upd_pc = '0;
  logic        upd_is_jump = 1'b0;
  logic        upd_taken = 1'b0;
  logic [31:0] upd_target = '0;
  logic        upd_pred_taken = 1'b0;
  logic [31:0] upd_pred_target = '0;
  logic        mispredict;
  logic [31:0] redirect_pc;
  logic [31:0] cnt_branches;
  logic [31:0] cnt_mispredicts;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  branch_predictor dut (
    .clk             (clk),
    .rst             (rst),
    .pc_f            (pc_f),
    .pred_taken      (pred_taken),
    .pred_target     (pred_target),
    .upd_valid       (upd_valid),
    .upd_pc          (upd_pc),
    .upd_is_jump     (upd_is_jump),
    .upd_taken       (upd_taken),
    .upd_target      (upd_target),
    .upd_pred_taken  (upd_pred_taken),
    .upd_pred_target (upd_pred_target),
    .mispredict      (mispredict),
    .redirect_pc     (redirect_pc),
    .cnt_branches    (cnt_branches),
    .cnt_mispredicts (cnt_mispredicts)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h @%0t", name, act, exp, $time);
    end
  endtask

  // Model: 64 entries, counter held as an integer strength 0..3.
  bit          m_valid [64];
  int unsigned m_tag   [64];
  int          m_str   [64];
  logic [31:0] m_tgt   [64];
  int unsigned m_nbr = 0;
  int unsigned m_nmp = 0;

  function automatic int midx(input logic [31:0] pc);
    return int'((pc >> 2) % 64);
  endfunction

  function automatic int unsigned mtag(input logic [31:0] pc);
    return (pc >> 8) % 256;
  endfunction

  function automatic bit m_hit(input logic [31:0] pc);
    return m_valid[midx(pc)] && (m_tag[midx(pc)] == mtag(pc));
  endfunction

  function automatic bit m_mispred();
    return upd_valid && ((upd_taken != upd_pred_taken) ||
                         (upd_taken && (upd_target != upd_pred_target)));
  endfunction

  always @(posedge clk) begin
    int i;
    i = midx(upd_pc);
    if (rst) begin
      for (int k = 0; k < 64; k++) begin
        m_valid[k] = 1'b0;
        m_str[k]   = 1;
      end
      m_nbr = 0;
      m_nmp = 0;
    end else if (upd_valid) begin
      m_nbr = m_nbr + 1;
      if (m_mispred()) m_nmp = m_nmp + 1;
      if (m_hit(upd_pc)) begin
        if (upd_is_jump) begin
          m_str[i] = 3;
          m_tgt[i] = upd_target;
        end else if (upd_taken) begin
          m_str[i] = (m_str[i] < 3) ? m_str[i] + 1 : 3;
          m_tgt[i] = upd_target;
        end else begin
          m_str[i] = (m_str[i] > 0) ? m_str[i] - 1 : 0;
        end
      end else if (upd_taken) begin
        m_valid[i] = 1'b1;
        m_tag[i]   = mtag(upd_pc);
        m_tgt[i]   = upd_target;
        m_str[i]   = upd_is_jump ? 3 : 2;
      end
    end
  end

  always @(negedge clk) begin
    bit h;
    if (chk_en) begin
      h = m_hit(pc_f);
      check("model pred_taken", {31'd0, pred_taken}, {31'd0, h && (m_str[midx(pc_f)] >= 2)});
      check("model pred_target", pred_target, h ? m_tgt[midx(pc_f)] : pc_f + 32'd4);
      check("model mispredict", {31'd0, mispredict}, {31'd0, m_mispred()});
      if (m_mispred())
        check("model redirect_pc", redirect_pc, upd_taken ? upd_target : upd_pc + 32'd4);
      check("model cnt_branches", cnt_branches, m_nbr);
      check("model cnt_mispredicts", cnt_mispredicts, m_nmp);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic look(input string name, input logic [31:0] pc, input logic tk,
                      input logic [31:0] tgt);
    pc_f = pc;
    #1;
    check({name, " taken"}, {31'd0, pred_taken}, {31'd0, tk});
    check({name, " target"}, pred_target, tgt);
  endtask

  task automatic set_upd(input logic [31:0] pc, input logic jmp, input logic tk,
                         input logic [31:0] tgt, input logic ptk, input logic [31:0] ptgt);
    upd_valid       = 1'b1;
    upd_pc          = pc;
    upd_is_jump     = jmp;
    upd_taken       = tk;
    upd_target      = tgt;
    upd_pred_taken  = ptk;
    upd_pred_target = ptgt;
    #1;
  endtask

  task automatic do_upd(input logic [31:0] pc, input logic jmp, input logic tk,
                        input logic [31:0] tgt);
    set_upd(pc, jmp, tk, tgt, 1'b0, pc + 32'd4);
    tick();
    upd_valid = 1'b0;
  endtask

  initial begin
    tick();
    chk_en = 1'b1;
    tick();
    rst = 1'b0;

    // Post-reset lookup
    look("reset 0x100", 32'h100, 1'b0, 32'h104);
    check("reset cnt_branches", cnt_branches, 32'd0);
    check("reset cnt_mispredicts", cnt_mispredicts, 32'd0);

    // Cold taken branch allocates weakly-taken
    set_upd(32'h100, 1'b0, 1'b1, 32'h40, 1'b0, 32'h104);
    check("cold mispredict", {31'd0, mispredict}, 32'd1);
    check("cold redirect", redirect_pc, 32'h40);
    tick();
    upd_valid = 1'b0;
    look("after alloc", 32'h100, 1'b1, 32'h40);
    check("cnt_branches 1", cnt_branches, 32'd1);
    check("cnt_mispredicts 1", cnt_mispredicts, 32'd1);

    // Hysteresis: WT -> WNT -> WT -> ST -> ST -> WT
    do_upd(32'h100, 1'b0, 1'b0, 32'h0);
    look("WT->WNT", 32'h100, 1'b0, 32'h40);
    for (int k = 0; k < 3; k++) do_upd(32'h100, 1'b0, 1'b1, 32'h40);
    do_upd(32'h100, 1'b0, 1'b0, 32'h0);
    look("ST saturates", 32'h100, 1'b1, 32'h40);
    for (int k = 0; k < 3; k++) do_upd(32'h100, 1'b0, 1'b0, 32'h0);
    look("down to SNT", 32'h100, 1'b0, 32'h40);
    do_upd(32'h100, 1'b0, 1'b0, 32'h0);
    do_upd(32'h100, 1'b0, 1'b1, 32'h40);
    look("SNT saturated, now WNT", 32'h100, 1'b0, 32'h40);
    do_upd(32'h100, 1'b0, 1'b1, 32'h40);
    look("back to WT", 32'h100, 1'b1, 32'h40);

    // Aliasing on idx 0
    look("alias miss", 32'h200, 1'b0, 32'h204);
    do_upd(32'h200, 1'b0, 1'b1, 32'h80);
    look("alias owner", 32'h200, 1'b1, 32'h80);
    look("evicted", 32'h100, 1'b0, 32'h104);

    // Miss not-taken: no allocation
    do_upd(32'h104, 1'b0, 1'b0, 32'h0);
    look("no alloc", 32'h104, 1'b0, 32'h108);

    // Jump allocates strongly-taken
    do_upd(32'h80, 1'b1, 1'b1, 32'h400);
    look("jal alloc", 32'h80, 1'b1, 32'h400);
    do_upd(32'h80, 1'b0, 1'b0, 32'h0);
    look("jal was ST", 32'h80, 1'b1, 32'h400);
    set_upd(32'h80, 1'b1, 1'b1, 32'h404, 1'b1, 32'h400);
    check("target mispredict", {31'd0, mispredict}, 32'd1);
    check("target redirect", redirect_pc, 32'h404);
    tick();
    set_upd(32'h80, 1'b1, 1'b1, 32'h404, 1'b1, 32'h404);
    check("correct jump", {31'd0, mispredict}, 32'd0);
    tick();
    set_upd(32'h84, 1'b0, 1'b0, 32'h0, 1'b1, 32'h90);
    check("nt mispredict", {31'd0, mispredict}, 32'd1);
    check("nt redirect", redirect_pc, 32'h88);
    tick();
    upd_valid = 1'b0;
    look("jal new target", 32'h80, 1'b1, 32'h404);

    // Read-during-write on 0x100
    pc_f = 32'h100;
    set_upd(32'h100, 1'b0, 1'b1, 32'h500, 1'b0, 32'h104);
    look("rdw old", 32'h100, 1'b0, 32'h104);
    tick();
    upd_valid = 1'b0;
    look("rdw new", 32'h100, 1'b1, 32'h500);

    // Reset with a concurrent update
    rst = 1'b1;
    set_upd(32'h80, 1'b1, 1'b1, 32'h600, 1'b0, 32'h84);
    tick();
    rst = 1'b0;
    upd_valid = 1'b0;
    check("rst cnt_branches", cnt_branches, 32'd0);
    check("rst cnt_mispredicts", cnt_mispredicts, 32'd0);
    look("rst clears 0x80", 32'h80, 1'b0, 32'h84);
    look("rst clears 0x100", 32'h100, 1'b0, 32'h104);
    tick();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
